// File: rtl/aemb2_mdu.sv
`default_nettype none
// ============================================================================
// Module   : aemb2_mdu
// Purpose  : Multi-cycle multiply/divide unit for the AEMB2 EX stage.
//            MUL, MULH (signed high), IDIV (signed) and IDIVU executed
//            iteratively at UNROLL result bits per cycle, tagged with the
//            issuing hardware thread. Supports abort and flags divide-by-zero.
// Ports    : gclk/grst      clock, synchronous active-high reset
//            dena           global pipeline enable (freezes all state when low)
//            mdu_stb/op     request strobe and opcode (sampled in IDLE only)
//            mdu_opa/opb    rA (multiplicand/divisor), rB (multiplier/dividend)
//            mdu_tag        thread id of request
//            mdu_kill       abort in-flight operation
//            mdu_bsy        busy, accept through result cycle
//            mdu_rdy        one-cycle result valid
//            mdu_res/rtg/dz result, result tag, divide-by-zero flag
// Revision : 1.0  initial release
// ============================================================================
module aemb2_mdu #(
  parameter int DW     = 32,
  parameter int UNROLL = 1,
  parameter int HTX    = 2,
  localparam int TW    = (HTX > 1) ? $clog2(HTX) : 1
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dena,
  input  logic          mdu_stb,
  input  logic [1:0]    mdu_op,
  input  logic [DW-1:0] mdu_opa,
  input  logic [DW-1:0] mdu_opb,
  input  logic [TW-1:0] mdu_tag,
  input  logic          mdu_kill,
  output logic          mdu_bsy,
  output logic          mdu_rdy,
  output logic [DW-1:0] mdu_res,
  output logic [TW-1:0] mdu_rtg,
  output logic          mdu_dz
);

  localparam int C_NSTEP = DW / UNROLL;
  localparam int C_CW    = $clog2(C_NSTEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [C_CW-1:0]   r_cnt;
  logic [1:0]        r_op;
  logic [TW-1:0]     r_tag;
  logic              r_neg;
  logic [DW-1:0]     r_opd;     // multiplicand or divisor
  logic [DW:0]       r_hi;      // partial product high / partial remainder
  logic [DW-1:0]     r_lo;      // multiplier shifting out / quotient shifting in
  logic [DW-1:0]     r_res;
  logic [TW-1:0]     r_rtg;
  logic              r_dz;

  logic              w_accept, w_dz, w_sgn_op, w_sa, w_sb, w_last;
  logic [DW-1:0]     w_maga, w_magb;
  logic [DW:0]       w_hi_f, w_sum, w_rs;
  logic [DW-1:0]     w_lo_f, w_mulh, w_fin;
  logic              w_ge;

  assign w_accept = (r_state == S_IDLE) && mdu_stb && !mdu_kill;
  assign w_dz     = mdu_op[1] && (mdu_opa == '0);
  // Only MULH and IDIV work on magnitudes; MUL low half is sign-agnostic.
  assign w_sgn_op = (mdu_op == 2'b01) || (mdu_op == 2'b10);
  assign w_sa     = w_sgn_op && mdu_opa[DW-1];
  assign w_sb     = w_sgn_op && mdu_opb[DW-1];
  assign w_maga   = w_sa ? -mdu_opa : mdu_opa;
  assign w_magb   = w_sb ? -mdu_opb : mdu_opb;
  assign w_last   = (r_state == S_CALC) && (r_cnt == C_CW'(C_NSTEP - 1));

  // UNROLL iterations of shift-add (multiply) or restoring subtract (divide).
  always_comb begin
    w_hi_f = r_hi;
    w_lo_f = r_lo;
    w_sum  = '0;
    w_rs   = '0;
    w_ge   = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      w_sum = w_hi_f + (w_lo_f[0] ? {1'b0, r_opd} : '0);
      w_rs  = {w_hi_f[DW-1:0], w_lo_f[DW-1]};
      w_ge  = (w_rs >= {1'b0, r_opd});
      if (r_op[1]) begin
        w_hi_f = w_ge ? (w_rs - {1'b0, r_opd}) : w_rs;
        w_lo_f = {w_lo_f[DW-2:0], w_ge};
      end else begin
        w_hi_f = {1'b0, w_sum[DW:1]};
        w_lo_f = {w_sum[0], w_lo_f[DW-1:1]};
      end
    end
  end

  // High half of the negated 2DW product: ~hi plus the carry out of -lo,
  // which is set only when the low half is zero.
  assign w_mulh = r_neg ? (~w_hi_f[DW-1:0] + {{(DW-1){1'b0}}, (w_lo_f == '0)})
                        : w_hi_f[DW-1:0];

  always_comb begin
    w_fin = w_lo_f;
    case (r_op)
      2'b00:   w_fin = w_lo_f;
      2'b01:   w_fin = w_mulh;
      default: w_fin = r_neg ? -w_lo_f : w_lo_f;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_dz ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (mdu_kill) w_next = S_IDLE;
  end

  always_ff @(posedge gclk) begin
    if (grst)      r_state <= S_IDLE;
    else if (dena) r_state <= w_next;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_tag <= '0;
      r_neg <= 1'b0;
      r_opd <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_res <= '0;
      r_rtg <= '0;
      r_dz  <= 1'b0;
    end else if (dena) begin
      if (w_accept) begin
        r_op  <= mdu_op;
        r_tag <= mdu_tag;
        r_neg <= w_sa ^ w_sb;
        r_opd <= w_maga;
        r_hi  <= '0;
        r_lo  <= w_magb;
        r_cnt <= '0;
        if (w_dz) begin
          r_res <= '0;
          r_dz  <= 1'b1;
          r_rtg <= mdu_tag;
        end
      end else if ((r_state == S_CALC) && !mdu_kill) begin
        r_hi  <= w_hi_f;
        r_lo  <= w_lo_f;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_res <= w_fin;
          r_dz  <= 1'b0;
          r_rtg <= r_tag;
        end
      end
    end
  end

  assign mdu_bsy = (r_state != S_IDLE);
  assign mdu_rdy = (r_state == S_DONE);
  assign mdu_res = r_res;
  assign mdu_rtg = r_rtg;
  assign mdu_dz  = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_aemb2_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_aemb2_mdu
// Purpose  : Self-checking bench for aemb2_mdu (UNROLL=1 and UNROLL=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_aemb2_mdu;

  logic        gclk = 1'b0;
  logic        grst, dena, stb, stb4, kill;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        tag;
  logic        bsy, rdy, dz, rtg;
  logic [31:0] res;
  logic        bsy4, rdy4, dz4, rtg4;
  logic [31:0] res4;

  int n_vec = 0;
  int n_bad = 0;

  always #5 gclk = ~gclk;

  aemb2_mdu #(.DW(32), .UNROLL(1), .HTX(2)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .mdu_stb(stb), .mdu_op(op),
    .mdu_opa(opa), .mdu_opb(opb), .mdu_tag(tag), .mdu_kill(kill),
    .mdu_bsy(bsy), .mdu_rdy(rdy), .mdu_res(res), .mdu_rtg(rtg), .mdu_dz(dz)
  );

  aemb2_mdu #(.DW(32), .UNROLL(4), .HTX(2)) dut4 (
    .gclk(gclk), .grst(grst), .dena(dena), .mdu_stb(stb4), .mdu_op(op),
    .mdu_opa(opa), .mdu_opb(opb), .mdu_tag(tag), .mdu_kill(kill),
    .mdu_bsy(bsy4), .mdu_rdy(rdy4), .mdu_res(res4), .mdu_rtg(rtg4), .mdu_dz(dz4)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        tag;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for rdy. Latency counts cycles after accept.
  // dena is dropped at latency count dat for dlen cycles when dat > 0.
  task automatic do_op(input bit u4, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic t, input int dat,
                       input int dlen, output int lat, output logic [31:0] r,
                       output logic d, output logic rt);
    @(negedge gclk);
    op = o; opa = a; opb = b; tag = t;
    if (u4) stb4 = 1'b1; else stb = 1'b1;
    @(negedge gclk);
    stb = 1'b0; stb4 = 1'b0;
    lat = 1;
    while (!(u4 ? rdy4 : rdy) && lat < 200) begin
      if (dat > 0 && lat == dat) dena = 1'b0;
      if (dat > 0 && lat == dat + dlen) dena = 1'b1;
      @(negedge gclk);
      lat++;
    end
    dena = 1'b1;
    r  = u4 ? res4 : res;
    d  = u4 ? dz4 : dz;
    rt = u4 ? rtg4 : rtg;
  endtask

  initial begin
    int          lat;
    logic [31:0] r;
    logic        d, rt, seen;

    tbl[0]  = '{2'b00, 32'd7,          32'd6,          1'b0, 32'd42,         1'b0, 33};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF,   32'd2,          1'b1, 32'hFFFFFFFF,   1'b0, 33};
    tbl[2]  = '{2'b10, 32'd2,          32'hFFFFFFF9,   1'b0, 32'hFFFFFFFD,   1'b0, 33};
    tbl[3]  = '{2'b11, 32'd2,          32'hFFFFFFFE,   1'b1, 32'h7FFFFFFF,   1'b0, 33};
    tbl[4]  = '{2'b10, 32'hFFFFFFFF,   32'h80000000,   1'b0, 32'h80000000,   1'b0, 33};
    tbl[5]  = '{2'b10, 32'd0,          32'd1234,       1'b1, 32'd0,          1'b1, 1};
    tbl[6]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          1'b0, 33};
    tbl[7]  = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'd0,          1'b0, 33};
    tbl[8]  = '{2'b01, 32'h12345678,   32'h00000010,   1'b0, 32'd1,          1'b0, 33};
    tbl[9]  = '{2'b11, 32'd0,          32'd5,          1'b0, 32'd0,          1'b1, 1};
    tbl[10] = '{2'b10, 32'hFFFFFFFE,   32'd7,          1'b1, 32'hFFFFFFFD,   1'b0, 33};
    tbl[11] = '{2'b10, 32'hFFFFFFFE,   32'hFFFFFFF9,   1'b0, 32'd3,          1'b0, 33};
    tbl[12] = '{2'b01, 32'h80000000,   32'h80000000,   1'b1, 32'h40000000,   1'b0, 33};
    tbl[13] = '{2'b00, 32'hFFFFFFFD,   32'd5,          1'b0, 32'hFFFFFFF1,   1'b0, 33};
    tbl[14] = '{2'b11, 32'd7,          32'd100,        1'b1, 32'd14,         1'b0, 33};
    tbl[15] = '{2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF,   1'b0, 32'h3FFFFFFF,   1'b0, 33};

    // Reset with stb held high: nothing accepted, all outputs zero.
    grst = 1'b1; dena = 1'b1; stb = 1'b1; stb4 = 1'b0; kill = 1'b0;
    op = 2'b00; opa = 32'd7; opb = 32'd6; tag = 1'b1;
    repeat (3) @(negedge gclk);
    chk("rst_bsy", {31'd0, bsy}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_rtg", {31'd0, rtg}, 32'd0);
    chk("rst_dz",  {31'd0, dz}, 32'd0);
    grst = 1'b0; stb = 1'b0;
    @(negedge gclk);
    chk("post_rst_bsy", {31'd0, bsy}, 32'd0);

    // Table of operations on the UNROLL=1 unit.
    for (int i = 0; i < 16; i++) begin
      do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, 0, 0, lat, r, d, rt);
      chk($sformatf("v%0d_res", i), r, tbl[i].res);
      chk($sformatf("v%0d_dz", i),  {31'd0, d}, {31'd0, tbl[i].dz});
      chk($sformatf("v%0d_rtg", i), {31'd0, rt}, {31'd0, tbl[i].tag});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Kill at CALC cycle 10: no rdy, bsy drops, previous result held.
    @(negedge gclk);
    op = 2'b00; opa = 32'd7; opb = 32'd6; tag = 1'b1; stb = 1'b1;
    @(negedge gclk);
    stb = 1'b0;
    repeat (9) @(negedge gclk);
    kill = 1'b1;
    @(negedge gclk);
    kill = 1'b0;
    chk("kill_bsy", {31'd0, bsy}, 32'd0);
    chk("kill_rdy", {31'd0, rdy}, 32'd0);
    chk("kill_res", res, 32'h3FFFFFFF);
    seen = 1'b0;
    repeat (40) begin
      @(negedge gclk);
      if (rdy) seen = 1'b1;
    end
    chk("kill_no_rdy", {31'd0, seen}, 32'd0);

    // stb and kill together in IDLE: not accepted.
    stb = 1'b1; kill = 1'b1;
    @(negedge gclk);
    stb = 1'b0; kill = 1'b0;
    chk("stbkill_bsy", {31'd0, bsy}, 32'd0);

    // dena low for 5 cycles mid-CALC delays rdy by exactly 5.
    do_op(1'b0, 2'b00, 32'd7, 32'd6, 1'b0, 10, 5, lat, r, d, rt);
    chk("dena_lat", 32'(lat), 32'd38);
    chk("dena_res", r, 32'd42);

    // dena low during DONE: rdy held, then retires on the first enabled edge.
    do_op(1'b0, 2'b00, 32'd3, 32'd5, 1'b1, 0, 0, lat, r, d, rt);
    chk("done_lat", 32'(lat), 32'd33);
    dena = 1'b0;
    seen = 1'b1;
    repeat (3) begin
      @(negedge gclk);
      if (!rdy) seen = 1'b0;
    end
    chk("done_hold_rdy", {31'd0, seen}, 32'd1);
    dena = 1'b1;
    @(negedge gclk);
    chk("done_rdy_once", {31'd0, rdy}, 32'd0);
    chk("done_res", res, 32'd15);
    chk("done_rtg", {31'd0, rtg}, 32'd1);

    // UNROLL=4 unit: 8 CALC cycles.
    do_op(1'b1, 2'b00, 32'd7, 32'd6, 1'b1, 0, 0, lat, r, d, rt);
    chk("u4_mul_lat", 32'(lat), 32'd9);
    chk("u4_mul_res", r, 32'd42);
    chk("u4_mul_rtg", {31'd0, rt}, 32'd1);
    do_op(1'b1, 2'b10, 32'd2, 32'hFFFFFFF9, 1'b0, 0, 0, lat, r, d, rt);
    chk("u4_div_lat", 32'(lat), 32'd9);
    chk("u4_div_res", r, 32'hFFFFFFFD);
    do_op(1'b1, 2'b01, 32'h80000000, 32'h80000000, 1'b0, 0, 0, lat, r, d, rt);
    chk("u4_mulh_res", r, 32'h40000000);

    @(negedge gclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
